axi_stream_fifo: RTL and testbench

Synchronous AXI4-Stream FIFO. It buffers beats between an upstream master and a downstream slave, and carries TDATA/TSTRB/TKEEP/TLAST/TID/TDEST/TUSER unmodified. Its s_ port is the point that the team's AXI-Stream slave property set checks, so the block must accept any legal upstream traffic. The m_ port must itself obey the AXI4-Stream master rules. It also reports beat occupancy and the number of complete packets it holds.

---
 rtl/axi_stream_pkg.sv | 37 +++
 rtl/sync_fifo_mem.sv | 37 +++
 rtl/axi_stream_fifo.sv | 155 +++++++++++++++
 tb/tb_axi_stream_fifo.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// Shared AXI4-Stream beat layout used by the stream blocks.
// A beat is packed LSB-first as: tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
package axi_stream_pkg;

    // tdata always starts at bit 0 of the packed beat
    localparam int DATA_LSB = 0;

    // Total packed width of one beat
    function automatic int payload_width(input int bw, input int idw, input int dw, input int uw);
        return 8*bw + 2*bw + 1 + idw + dw + uw;
    endfunction

    function automatic int strb_lsb(input int bw);
        return 8*bw;
    endfunction

    function automatic int keep_lsb(input int bw);
        return 9*bw;
    endfunction

    function automatic int last_bit(input int bw);
        return 10*bw;
    endfunction

    function automatic int id_lsb(input int bw);
        return 10*bw + 1;
    endfunction

    function automatic int dest_lsb(input int bw, input int idw);
        return 10*bw + 1 + idw;
    endfunction

    function automatic int user_lsb(input int bw, input int idw, input int dw);
        return 10*bw + 1 + idw + dw;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array: one write port, one registered read port.
// Contents and the read register are deliberately not reset.
module sync_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] rd_data_q;

    // Write port: store the beat verbatim
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port: only advances when the consumer asks, so it holds otherwise
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_stream_fifo.sv
// Synchronous AXI4-Stream FIFO with first-word-fall-through output.
// The memory read register is the output stage: a beat written at edge N is
// read out at edge N+1, and the read register is frozen while the output stalls.
module axi_stream_fifo #(
    parameter int byte_width = 4,
    parameter int id_width   = 1,
    parameter int dest_width = 1,
    parameter int user_width = 1,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [8*byte_width-1:0] s_tdata,
    input  logic [byte_width-1:0]   s_tstrb,
    input  logic [byte_width-1:0]   s_tkeep,
    input  logic                    s_tlast,
    input  logic [id_width-1:0]     s_tid,
    input  logic [dest_width-1:0]   s_tdest,
    input  logic [user_width-1:0]   s_tuser,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [8*byte_width-1:0] m_tdata,
    output logic [byte_width-1:0]   m_tstrb,
    output logic [byte_width-1:0]   m_tkeep,
    output logic                    m_tlast,
    output logic [id_width-1:0]     m_tid,
    output logic [dest_width-1:0]   m_tdest,
    output logic [user_width-1:0]   m_tuser,
    output logic [DEPTH_LOG2:0]     count,
    output logic [DEPTH_LOG2:0]     pkt_count
);

    import axi_stream_pkg::*;

    localparam int PW     = payload_width(byte_width, id_width, dest_width, user_width);
    localparam int DATA_W = 8*byte_width;

    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DEPTH_LOG2:0]   pkt_count_q, pkt_count_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  s_tready_q, s_tready_d;

    logic          push;
    logic          pop;
    logic          mem_has_beat;
    logic          rd_en;
    logic [PW-1:0] wr_payload;
    logic [PW-1:0] rd_payload;
    logic [PW-1:0] out_payload;

    assign wr_payload = {s_tuser, s_tdest, s_tid, s_tlast, s_tkeep, s_tstrb, s_tdata};

    sync_fifo_mem #(
        .WIDTH  (PW),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_payload),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_payload)
    );

    // Next-state for pointers, counters, output valid and registered ready
    always_comb begin
        push = s_tvalid && s_tready_q;
        pop  = m_tvalid_q && m_tready;

        // Beats still in the array that have not yet moved to the output stage
        mem_has_beat = (count_q != {{DEPTH_LOG2{1'b0}}, m_tvalid_q});
        // Refill the output stage when it is empty or being drained this edge
        rd_en = mem_has_beat && (!m_tvalid_q || m_tready);

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        pkt_count_d = pkt_count_q;
        if ((push && s_tlast) && !(pop && m_tlast)) begin
            pkt_count_d = pkt_count_q + CNT_ONE;
        end else if ((pop && m_tlast) && !(push && s_tlast)) begin
            pkt_count_d = pkt_count_q - CNT_ONE;
        end

        m_tvalid_d = m_tvalid_q;
        if (rd_en) begin
            m_tvalid_d = 1'b1;
        end else if (pop) begin
            m_tvalid_d = 1'b0;
        end

        // Ready is a function of the next occupancy only, never of m_tready directly
        s_tready_d = (count_d != FULL_LEVEL);
    end

    // Control state, cleared asynchronously; the array itself is left alone
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
            m_tvalid_q  <= 1'b0;
            s_tready_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
            m_tvalid_q  <= m_tvalid_d;
            s_tready_q  <= s_tready_d;
        end
    end

    // The read register is not reset, so the payload is forced to zero whenever
    // no beat is presented; this also gives an all-zero payload during reset.
    assign out_payload = rd_payload & {PW{m_tvalid_q}};

    assign m_tdata  = out_payload[DATA_LSB +: DATA_W];
    assign m_tstrb  = out_payload[strb_lsb(byte_width) +: byte_width];
    assign m_tkeep  = out_payload[keep_lsb(byte_width) +: byte_width];
    assign m_tlast  = out_payload[last_bit(byte_width)];
    assign m_tid    = out_payload[id_lsb(byte_width) +: id_width];
    assign m_tdest  = out_payload[dest_lsb(byte_width, id_width) +: dest_width];
    assign m_tuser  = out_payload[user_lsb(byte_width, id_width, dest_width) +: user_width];

    assign m_tvalid  = m_tvalid_q;
    assign s_tready  = s_tready_q;
    assign count     = count_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Bench for axi_stream_fifo (DEPTH_LOG2=2): a cycle table for the basic flow,
// hand-written sequences for full, stall, wrap and reset, and a scoreboard
// that checks every delivered beat against the beats that were accepted.
module tb_axi_stream_fifo;

    typedef struct packed {
        logic        user;
        logic        dest;
        logic        id;
        logic        last;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        sv;
        logic [31:0] d;
        logic        last;
        logic        mr;
        int          exp_count;
        int          exp_pkt;
        logic        exp_mv;
        logic [31:0] exp_md;
        logic        exp_sr;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        s_tvalid;
    logic        s_tready;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [0:0]  m_tid;
    logic [0:0]  m_tdest;
    logic [0:0]  m_tuser;
    logic [2:0]  count;
    logic [2:0]  pkt_count;
    beat_t       s_beat;
    beat_t       m_beat;

    int errors = 0;
    int checks = 0;
    beat_t sb[$];

    axi_stream_fifo #(
        .byte_width (4),
        .id_width   (1),
        .dest_width (1),
        .user_width (1),
        .DEPTH_LOG2 (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_beat.data),
        .s_tstrb   (s_beat.strb),
        .s_tkeep   (s_beat.keep),
        .s_tlast   (s_beat.last),
        .s_tid     (s_beat.id),
        .s_tdest   (s_beat.dest),
        .s_tuser   (s_beat.user),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tstrb   (m_tstrb),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tid     (m_tid),
        .m_tdest   (m_tdest),
        .m_tuser   (m_tuser),
        .count     (count),
        .pkt_count (pkt_count)
    );

    assign m_beat = {m_tuser, m_tdest, m_tid, m_tlast, m_tkeep, m_tstrb, m_tdata};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk_beat(input logic [31:0] d, input logic last);
        beat_t b;
        b      = '0;
        b.data = d;
        b.strb = 4'hF;
        b.keep = 4'hF;
        b.last = last;
        return b;
    endfunction

    // Empty the FIFO with the sink always ready, bounded in cycles
    task automatic drain(input string name);
        int n;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        n = 0;
        while (count != 3'd0 && n < 100) begin
            tick();
            n++;
        end
        check({name, "_drain_count"}, count, 0);
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_pkt_zero"}, pkt_count, 0);
        m_tready = 1'b0;
    endtask

    // Monitor: sampled on the falling edge; the handshakes seen here take effect at the next rising edge
    initial begin
        logic  prev_stall;
        beat_t prev_beat;
        beat_t exp_beat;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", m_tvalid, 1);
                    check("hold_payload", m_beat, prev_beat);
                end
                if (m_tvalid && m_tready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_beat);
                    end else begin
                        exp_beat = sb.pop_front();
                        check("beat_out", m_beat, exp_beat);
                        $display("beat out 0x%0h", m_beat);
                    end
                end
                if (s_tvalid && s_tready) begin
                    sb.push_back(s_beat);
                end
                prev_stall = m_tvalid && !m_tready;
                prev_beat  = m_beat;
            end
        end
    end

    initial begin
        vec_t  vecs[6];
        beat_t cbeats[20];
        logic [3:0] keeps[4];
        logic [3:0] strbs[4];
        int    idx;
        int    n;
        logic  acc;

        vecs[0] = '{1'b1, 32'h11111111, 1'b0, 1'b1, 1, 0, 1'b0, 32'h0,        1'b1};
        vecs[1] = '{1'b1, 32'h22222222, 1'b0, 1'b1, 2, 0, 1'b1, 32'h11111111, 1'b1};
        vecs[2] = '{1'b1, 32'h33333333, 1'b0, 1'b1, 2, 0, 1'b1, 32'h22222222, 1'b1};
        vecs[3] = '{1'b1, 32'h44444444, 1'b1, 1'b1, 2, 1, 1'b1, 32'h33333333, 1'b1};
        vecs[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 1, 1, 1'b1, 32'h44444444, 1'b1};
        vecs[5] = '{1'b0, 32'h0,        1'b0, 1'b1, 0, 0, 1'b0, 32'h0,        1'b1};

        keeps[0] = 4'b0111; keeps[1] = 4'b0101; keeps[2] = 4'b1000; keeps[3] = 4'b0000;
        strbs[0] = 4'b0101; strbs[1] = 4'b0001; strbs[2] = 4'b1110; strbs[3] = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            cbeats[i]      = '0;
            cbeats[i].data = $urandom;
            cbeats[i].keep = keeps[i % 4];
            cbeats[i].strb = strbs[(i / 4) % 4];
            cbeats[i].last = ((i % 5) == 4);
            cbeats[i].id   = 1'($urandom_range(0, 1));
            cbeats[i].dest = 1'($urandom_range(0, 1));
            cbeats[i].user = 1'($urandom_range(0, 1));
        end

        // Reset state
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        s_beat   = '0;
        tick();
        tick();
        check("rst_count", count, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_mvalid", m_tvalid, 0);
        check("rst_sready", s_tready, 0);
        check("rst_mpayload", m_beat, 0);
        resetn = 1'b1;
        check("release_sready_before_edge", s_tready, 0);
        tick();
        check("release_sready", s_tready, 1);

        // Table: four beats straight through, one-cycle latency
        for (int i = 0; i < 6; i++) begin
            s_tvalid = vecs[i].sv;
            s_beat   = mk_beat(vecs[i].d, vecs[i].last);
            m_tready = vecs[i].mr;
            tick();
            $display("vec %0d: count=%0d pkt=%0d mvalid=%0b mdata=0x%08h sready=%0b",
                     i, count, pkt_count, m_tvalid, m_tdata, s_tready);
            check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            check($sformatf("vec%0d_pkt", i), pkt_count, vecs[i].exp_pkt);
            check($sformatf("vec%0d_mvalid", i), m_tvalid, vecs[i].exp_mv);
            check($sformatf("vec%0d_mdata", i), m_tdata, vecs[i].exp_md);
            check($sformatf("vec%0d_sready", i), s_tready, vecs[i].exp_sr);
        end
        check("basic_sb_empty", sb.size(), 0);

        // Full: six beats offered with the sink stalled
        m_tready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            s_tvalid = 1'b1;
            s_beat   = mk_beat(32'hA0 + 32'(idx), idx == 5);
            acc      = s_tready;
            tick();
            if (acc) idx++;
        end
        check("full_accepted", idx, 4);
        check("full_count", count, 4);
        check("full_sready", s_tready, 0);
        check("full_mvalid", m_tvalid, 1);
        check("full_mdata", m_tdata, 32'hA0);
        m_tready = 1'b1;
        acc = s_tready;
        tick();
        if (acc) idx++;
        m_tready = 1'b0;
        check("pop1_count", count, 3);
        check("pop1_sready", s_tready, 1);
        check("pop1_mdata", m_tdata, 32'hA1);
        m_tready = 1'b1;
        n = 0;
        while (idx < 6 && n < 50) begin
            s_tvalid = 1'b1;
            s_beat   = mk_beat(32'hA0 + 32'(idx), idx == 5);
            acc      = s_tready;
            tick();
            if (acc) idx++;
            n++;
        end
        check("full_all_sent", idx, 6);
        drain("full");

        // Random sink stalls with odd strobe/keep patterns
        idx = 0;
        n = 0;
        while (idx < 20 && n < 500) begin
            m_tready = 1'($urandom_range(0, 1));
            s_tvalid = 1'b1;
            s_beat   = cbeats[idx];
            acc      = s_tready;
            tick();
            if (acc) idx++;
            n++;
        end
        check("stall_all_sent", idx, 20);
        drain("stall");

        // Steady push and pop at occupancy 2, pointers wrap several times
        m_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid = 1'b1;
            s_beat   = mk_beat(32'hC000 + 32'(i), 1'b0);
            tick();
        end
        check("wrap_pre_count", count, 2);
        m_tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_tvalid = 1'b1;
            s_beat   = mk_beat(32'hC100 + 32'(i), (i % 3) == 2);
            tick();
            check($sformatf("wrap%0d_count", i), count, 2);
        end
        drain("wrap");

        // Reset in the middle of a transfer
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_beat   = mk_beat(32'hD0 + 32'(i), 1'b1);
            tick();
        end
        s_tvalid = 1'b0;
        check("mid_count", count, 3);
        check("mid_mvalid", m_tvalid, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_mvalid", m_tvalid, 0);
        check("async_count", count, 0);
        check("async_pkt", pkt_count, 0);
        sb.delete();
        tick();
        resetn = 1'b1;
        check("rerel_sready_before_edge", s_tready, 0);
        tick();
        check("rerel_sready", s_tready, 1);
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_beat   = mk_beat(32'hE0E0E0E0, 1'b1);
        tick();
        s_tvalid = 1'b0;
        tick();
        check("post_rst_mvalid", m_tvalid, 1);
        check("post_rst_mdata", m_tdata, 32'hE0E0E0E0);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
